// File: rtl/carry_bypass_seq_adder.sv
// carry_bypass_seq_adder: multi-cycle WIDTH-bit adder reusing one CHUNK-bit carry-bypass slice per cycle.
// Optional subtraction (A-B, oC = not-borrow) is built only when CBSEQ_SUB_EN is defined.

// carry_bypass_block: combinational carry-skip adder slice; carry bypasses each GROUP when all bits propagate.
module carry_bypass_block #(
    parameter int WIDTH = 4,
    parameter int GROUP = 2
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    logic c;
    logic c_grp;
    logic p;
    logic p_all;
    always_comb begin
        oS    = '0;
        c     = iC;
        c_grp = iC;
        p     = 1'b0;
        p_all = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            p     = iA[i] ^ iB[i];
            oS[i] = p ^ c;
            c     = (iA[i] & iB[i]) | (p & c);
            p_all = p_all & p;
            if ((i % GROUP) == GROUP - 1 || i == WIDTH - 1) begin
                c     = p_all ? c_grp : c;
                c_grp = c;
                p_all = 1'b1;
            end
        end
        oC = c;
    end
endmodule

module carry_bypass_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $fatal(1, "carry_bypass_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic            c_q, c_d;
    logic            armed_q;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic            slice_c;
    logic [WIDTH-1:0] b_in;
    logic            c_in;

    // Subtraction is folded in at accept: B is stored inverted and the carry register seeded with 1.
`ifdef CBSEQ_SUB_EN
    assign b_in = iSub ? ~iB : iB;
    assign c_in = iSub | iC;
`else
    logic unused_sub;
    assign unused_sub = iSub;
    assign b_in       = iB;
    assign c_in       = iC;
`endif

    assign slice_a = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    assign slice_b = b_q[int'(cnt_q) * CHUNK +: CHUNK];

    carry_bypass_block #(
        .WIDTH(CHUNK)
    ) u_slice (
        .iA(slice_a),
        .iB(slice_b),
        .iC(c_q),
        .oS(slice_s),
        .oC(slice_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        oReady  = armed_q && state_q == IDLE;
        oValid  = state_q == DONE;
        if (state_q == IDLE && oReady && iValid) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = iA;
            b_d     = b_in;
            c_d     = c_in;
        end
        if (state_q == RUN) begin
            s_d[int'(cnt_q) * CHUNK +: CHUNK] = slice_s;
            c_d     = slice_c;
            cnt_d   = cnt_q + CW'(1);
            state_d = (int'(cnt_q) == N - 1) ? DONE : RUN;
        end
        if (state_q == DONE && iReady) state_d = IDLE;
    end

    // armed_q keeps oReady low while reset is held and for the edge that follows release.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            armed_q <= 1'b1;
        end
    end

    assign oS = s_q;
    assign oC = c_q;
endmodule

// File: doc/carry_bypass_seq_adder.md
# carry_bypass_seq_adder

Multi-cycle wide adder controller that sequences a single CHUNK-bit `carry_bypass_block` instance across WIDTH/CHUNK cycles to add two WIDTH-bit operands. The adder slice is reused once per chunk, with the chunk carry registered between cycles. Operands and results move over valid/ready handshakes, so the block drops into accumulator and ALU paths where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of CHUNK (elaboration-time check, fatal otherwise).
- CHUNK, 4, width of the internal `carry_bypass_block` slice (its WIDTH parameter).

- iClk  input  1  clock, rising edge.
- iRst_n  input  1  reset; asynchronous assert, active-low.
- iValid  input  1  operand request valid.
- oReady  output  1  block can accept operands.
- iA  input  WIDTH  operand A.
- iB  input  WIDTH  operand B.
- iC  input  1  carry-in.
- iSub  input  1  subtract request; only honoured when CBSEQ_SUB_EN is defined.
- oValid  output  1  result valid.
- iReady  input  1  consumer accepts result.
- oS  output  WIDTH  sum/difference.
- oC  output  1  carry-out of the MSB chunk. With subtraction this is the not-borrow flag.

## Operation
- States: IDLE, RUN, DONE. A 2-bit state register is sufficient.
- IDLE:
  - oReady=1, oValid=0.
  - On iValid&oReady: latch iA, iB, iC and iSub into internal registers.
  - Clear the chunk counter to 0 and go to RUN.
- RUN:
  - oReady=0, oValid=0.
  - The slice adds A[cnt*CHUNK +: CHUNK] and B'[cnt*CHUNK +: CHUNK] with carry-in c.
  - c is the latched iC for cnt=0, and the registered slice oC otherwise.
  - Each edge writes the slice sum into the result register at chunk cnt, registers the slice carry, and increments cnt.
  - When cnt==N-1, where N=WIDTH/CHUNK, go to DONE on that edge.
- DONE:
  - oValid=1; oS and oC hold constant.
  - On iValid... no: on oValid&iReady, go to IDLE.
  - iValid is ignored outside IDLE.
- B' is B, or ~B with forced carry-in 1 when subtract is active (see Configuration).
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - oC is the true carry out of bit WIDTH-1.
  - cnt has width max(1, clog2(N)).
  - N=1 is legal: a single RUN cycle.
- Reset (iRst_n low, at any time including mid-RUN or DONE):
  - State goes to IDLE immediately; the counter and carry register clear.
  - oS=0, oC=0, oValid=0.
  - oReady=1 once reset is released. oReady is 0 while reset is asserted.
  - Any in-flight operation is discarded with no output.

## Timing
- Accept edge T: iValid&oReady sampled high.
- RUN occupies the cycles after edges T..T+N-1.
- oValid rises after edge T+N, so latency is N cycles from accept to oValid.
- Backpressure: oValid stays high and oS/oC stay stable until the edge where iReady=1.
- oReady rises one cycle after result consumption. This gives a minimum spacing of N+2 cycles between accepts.
- The slice path is combinational from registers to registers. There is no combinational path from any input to any output.
- oReady and oValid are decoded directly from the state register.

## Configuration
- CBSEQ_SUB_EN defined:
  - iSub is latched at accept.
  - When the latched iSub=1, B' = ~B and the chunk-0 carry-in is forced to 1, giving A−B. iC is ignored in that case.
  - oC=1 means no borrow.
- CBSEQ_SUB_EN undefined:
  - iSub is accepted but ignored; no inverter or mux logic is generated.
  - The block always computes A+B+iC.

## Test plan
WIDTH=16 and CHUNK=4 unless noted.

- Basic add: A=0xFFFF, B=0x0001, iC=0 → oS=0x0000, oC=1, oValid exactly 4 cycles after the accept edge.
- Chunk-boundary carry: A=0x00F0, B=0x0010, iC=1 → oS=0x0101, oC=0. Checks the carry-register handoff between chunks.
- Backpressure: hold iReady=0 for 10 cycles in DONE → oS/oC/oValid stable and oReady=0 throughout. Raise iReady → IDLE, oReady=1 next cycle. iValid pulses during RUN/DONE are ignored.
- Reset mid-RUN: assert iRst_n=0 at cnt=2 → oValid=0, oS=0, oC=0 immediately. After release, a new op A=0x1234, B=0x4321 → oS=0x5555, oC=0.
- Subtract, with CBSEQ_SUB_EN: A=0x0005, B=0x0007, iSub=1 → oS=0xFFFE, oC=0. A=0x0007, B=0x0005 → oS=0x0002, oC=1. Without the macro, the same stimulus gives 0x000C and oC=0.
- Degenerate N=1 (WIDTH=4, CHUNK=4): A=0xF, B=0x1 → oS=0x0, oC=1, oValid 1 cycle after accept.
